// File: rtl/print_reader.sv
// ----------------------------------------------------------------------------
// print_reader
//   Scans a read-only print memory from word 0 and streams the low byte of
//   each word to a valid/ready consumer. The scan stops at the first 0x00
//   byte or after the last word (DEPTH-1), whichever comes first.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   start       request a new scan (honoured only while idle)
//   rd_addr     byte address of the word being read (bits [1:0] = 0)
//   rd_data     read data, valid one cycle after rd_addr (registered read)
//   char_o      character to the consumer
//   char_valid  char_o is valid
//   char_ready  consumer accepts char_o when high together with char_valid
//   busy        high whenever the scanner is not idle
//   done        one-cycle pulse at the end of a completed scan
//   count       characters accepted in the current or last scan
// ----------------------------------------------------------------------------
module print_reader #(
    parameter int DEPTH = 700,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic [7:0]    char_o,
    output logic          char_valid,
    input  logic          char_ready,
    output logic          busy,
    output logic          done,
    output logic [9:0]    count
);

    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]    char_q, char_d;
    logic [9:0]    count_q, count_d;

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no
        // path through the case below can infer a latch.
        state_d = state_q;
        index_d = index_q;
        char_d  = char_q;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d = '0;
                    count_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only the low byte carries the character; a 0x00 terminates.
                char_d  = rd_data[7:0];
                state_d = (rd_data[7:0] == 8'h00) ? ST_DONE : ST_EMIT;
            end
            ST_EMIT: begin
                if (char_ready) begin
                    count_d = count_q + 10'd1;
                    if (index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + IW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address is registered from the next index so that it already reflects a
    // freshly cleared or incremented index in the FETCH cycle.
    assign rd_addr_d = AW'({index_d, 2'b00});

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            rd_addr_q <= '0;
            char_q    <= 8'h00;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            rd_addr_q <= rd_addr_d;
            char_q    <= char_d;
            count_q   <= count_d;
        end
    end

    // Status outputs decode the state register directly, so reset clears
    // char_valid, busy and done asynchronously.
    assign rd_addr    = rd_addr_q;
    assign char_o     = char_q;
    assign char_valid = (state_q == ST_EMIT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign count      = count_q;

endmodule

// File: tb/tb_print_reader.sv
// ----------------------------------------------------------------------------
// tb_print_reader
//   Self-checking bench for print_reader: a table of hand-computed vectors,
//   hand-written reset/full-depth sequences, and randomized memory images
//   checked against a string-level reference model.
// ----------------------------------------------------------------------------
module tb_print_reader;

    localparam int DEPTH  = 700;
    localparam int AW     = 14;
    localparam int BUDGET = 3 * DEPTH + 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    char_o;
    logic          char_valid;
    logic          char_ready;
    logic          busy;
    logic          done;
    logic [9:0]    count;

    logic [31:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    // Results of the most recent scan
    logic [7:0]    got[$];
    logic [AW-1:0] addrs[$];
    int            done_cnt;
    int            done_at;
    int            bad_cycles;
    bit            timed_out;

    print_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .char_o     (char_o),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] read_mem(input logic [AW-1:0] a);
        int i;
        i = int'(a[AW-1:2]);
        if (i < DEPTH) return mem[i];
        return 32'hBAD0_00EE;
    endfunction

    // Registered-read memory model
    always @(posedge clk) rd_data <= read_mem(rd_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the printed string is the low bytes of consecutive
    // words up to (not including) the first zero byte, at most DEPTH long.
    task automatic model(output logic [7:0] q[$], output bit full);
        q.delete();
        full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i][7:0] == 8'h00) begin
                full = 1'b0;
                break;
            end
            q.push_back(mem[i][7:0]);
        end
    endtask

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < DEPTH; i++) mem[i] = v;
    endtask

    // Pulse start, then drive char_ready and observe every cycle until done.
    // Sample index n = 0 is the first cycle after start is sampled.
    task automatic run_scan(input bit rand_ready, input int low_cycles, input bit busy_start);
        int         n;
        int         low_left;
        bit         stalled;
        bit         seen;
        bit         rdy;
        logic [7:0] prev_c;
        got.delete();
        addrs.delete();
        done_cnt   = 0;
        done_at    = -1;
        bad_cycles = 0;
        timed_out  = 1'b0;
        low_left   = low_cycles;
        stalled    = 1'b0;
        seen       = 1'b0;
        prev_c     = 8'h00;
        n          = 0;
        @(negedge clk);
        start      = 1'b1;
        char_ready = 1'b1;
        while (!seen && n < BUDGET) begin
            @(negedge clk);
            start = busy_start && (n == 4);
            if (stalled && (!char_valid || char_o !== prev_c)) bad_cycles++;
            if (char_valid && !busy) bad_cycles++;
            if (busy && (addrs.size() == 0 || addrs[$] !== rd_addr)) addrs.push_back(rd_addr);
            if (done) begin
                done_cnt++;
                done_at = n;
                seen    = 1'b1;
            end
            if (char_valid && low_left > 0) begin
                rdy = 1'b0;
                low_left--;
            end else if (rand_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            char_ready = rdy;
            if (char_valid && rdy) got.push_back(char_o);
            stalled = char_valid && !rdy;
            prev_c  = char_o;
            n++;
        end
        start = 1'b0;
        if (!seen) timed_out = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (char_valid) bad_cycles++;
        end
    endtask

    task automatic verify(input string tag, input logic [7:0] exp[$], input bit full, input bit timed);
        int mism;
        int n_addr;
        check({tag, ".timeout"}, timed_out, 0);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".count"}, count, exp.size());
        check({tag, ".nchars"}, got.size(), exp.size());
        mism = 0;
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            if (got[i] !== exp[i]) mism++;
        check({tag, ".char_mismatches"}, mism, 0);
        n_addr = full ? DEPTH : exp.size() + 1;
        check({tag, ".naddrs"}, addrs.size(), n_addr);
        mism = 0;
        for (int i = 0; i < addrs.size(); i++)
            if (addrs[i] !== AW'(i * 4)) mism++;
        check({tag, ".addr_mismatches"}, mism, 0);
        check({tag, ".protocol_errors"}, bad_cycles, 0);
        check({tag, ".idle_after"}, busy, 0);
        if (timed)
            check({tag, ".done_latency"}, done_at, full ? 3 * DEPTH : 3 * exp.size() + 2);
    endtask

    typedef struct packed {
        logic [31:0] w0, w1, w2, w3;
        logic [3:0]  low;
        logic        bstart;
        logic [1:0]  n;
        logic [7:0]  c0, c1, c2;
    } vec_t;

    localparam int NV = 5;

    initial begin
        vec_t       vecs [NV];
        logic [7:0] e[$];
        bit         full;
        bit         ok;
        int         len;

        vecs[0] = '{32'h48, 32'h69, 32'h00, 32'h00, 4'd0, 1'b0, 2'd2, 8'h48, 8'h69, 8'h00};
        vecs[1] = '{32'h00, 32'h41, 32'h42, 32'h00, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFF41, 32'h00, 32'h00, 32'h00, 4'd5, 1'b0, 2'd1, 8'h41, 8'h00, 8'h00};
        vecs[3] = '{32'h12345642, 32'hAABBCC00, 32'h43, 32'h00, 4'd0, 1'b0, 2'd1, 8'h42, 8'h00, 8'h00};
        vecs[4] = '{32'h31, 32'h32, 32'h33, 32'h00, 4'd0, 1'b1, 2'd3, 8'h31, 8'h32, 8'h33};

        rst        = 1'b1;
        start      = 1'b0;
        char_ready = 1'b0;
        fill_mem(32'h0);
        repeat (3) @(negedge clk);
        check("reset.rd_addr", rd_addr, 0);
        check("reset.char_o", char_o, 0);
        check("reset.char_valid", char_valid, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.count", count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.waits_idle", busy, 0);

        // Table-driven vectors; words beyond w3 are nonzero garbage so only
        // the zero low byte can end the scan.
        for (int v = 0; v < NV; v++) begin
            fill_mem(32'h0000_0077);
            mem[0] = vecs[v].w0;
            mem[1] = vecs[v].w1;
            mem[2] = vecs[v].w2;
            mem[3] = vecs[v].w3;
            e.delete();
            if (vecs[v].n > 0) e.push_back(vecs[v].c0);
            if (vecs[v].n > 1) e.push_back(vecs[v].c1);
            if (vecs[v].n > 2) e.push_back(vecs[v].c2);
            run_scan(1'b0, int'(vecs[v].low), vecs[v].bstart);
            verify($sformatf("vec%0d", v), e, 1'b0, vecs[v].low == 0);
        end

        // Reset during EMIT of the second character
        fill_mem(32'h0);
        mem[0] = 32'h41;
        mem[1] = 32'h42;
        mem[2] = 32'h43;
        @(negedge clk);
        start      = 1'b1;
        char_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (count == 10'd1) ok = 1'b1;
        end
        char_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (char_valid) ok = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid.reached_emit2", char_valid, 1);
        check("rst_mid.char_before", char_o, 8'h42);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.char_valid", char_valid, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.count", count, 0);
        check("rst_mid.rd_addr", rd_addr, 0);
        check("rst_mid.char_o", char_o, 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_mid.no_done", done_cnt, 0);
        check("rst_mid.waits_idle", busy, 0);
        model(e, full);
        run_scan(1'b0, 0, 1'b0);
        verify("rst_mid.rescan", e, full, 1'b1);

        // Randomized images with random backpressure
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] = {$urandom_range(0, 32'hFF_FFFF), 8'($urandom_range(1, 255))};
            len = $urandom_range(0, 14);
            mem[len][7:0] = 8'h00;
            model(e, full);
            run_scan(1'b1, 0, 1'b0);
            verify($sformatf("rand%0d", r), e, full, 1'b0);
        end

        // Full depth: no terminator, index must stop at DEPTH-1
        fill_mem(32'h0000_002E);
        model(e, full);
        check("full.model_len", e.size(), DEPTH);
        run_scan(1'b0, 0, 1'b0);
        verify("full", e, full, 1'b1);
        check("full.last_rd_addr", rd_addr, 14'hAEC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/print_reader.md
PRINT_READER -- requirements
Module: print_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 700, giving the number of 32-bit words in the print memory.
REQ-002 The block SHALL have parameter AW, default 14, giving the byte-address width of the print memory.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to scan the print memory from word 0.
REQ-006 Port rd_addr  output  AW  byte address of the word being read; bits [1:0] always 0, word index in rd_addr[AW-1:2].
REQ-007 Port rd_data  input  32  read data; valid exactly 1 cycle after rd_addr is presented (registered read).
REQ-008 Port char_o  output  8  ASCII character to the downstream consumer.
REQ-009 Port char_valid  output  1  char_o holds a valid character.
REQ-010 Port char_ready  input  1  consumer accepts char_o when high in the same cycle as char_valid.
REQ-011 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 Port done  output  1  one-cycle pulse when a scan ends.
REQ-013 Port count  output  10  number of characters accepted in the current or last scan.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT, EMIT, and DONE.
REQ-015 IDLE: on start=1, clear the word index and count, then go to FETCH; otherwise remain in IDLE.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 FETCH: drive rd_addr = index*4 (rd_addr is registered from the index in all states), then go to WAIT after one cycle.
REQ-018 WAIT: capture rd_data[7:0] into the character register; rd_data[31:8] SHALL be ignored.
REQ-019 WAIT: if the captured byte is 0x00, go to DONE with no character emitted; otherwise go to EMIT.
REQ-020 EMIT: char_valid=1 and char_o=captured byte.
REQ-021 EMIT: char_o SHALL stay stable until the cycle char_valid & char_ready is seen.
REQ-022 EMIT handshake: count increments by 1 in the handshake cycle.
REQ-023 EMIT handshake: if index == DEPTH-1, go to DONE; otherwise increment the index and go to FETCH.
REQ-024 The index SHALL never wrap to 0 within a scan; the maximum count is DEPTH (700 < 1024, so there is no overflow).
REQ-025 char_valid SHALL be 0 in all states except EMIT, and SHALL never drop in EMIT without a handshake.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE; count holds its value until the next accepted start.
REQ-027 Minimum cost per character SHALL be 3 cycles (FETCH, WAIT, EMIT with char_ready=1).
REQ-028 busy SHALL be 1 in FETCH, WAIT, EMIT, and DONE; 0 in IDLE.
REQ-029 The block SHALL never write the print memory (read-only consumer).

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, index 0, rd_addr 0, char_o 0x00, char_valid 0, busy 0, done 0, count 0.
REQ-031 rst asserted mid-scan, including in EMIT with char_valid=1, SHALL abort the scan without a done pulse; char_valid deasserts asynchronously.
REQ-032 After rst deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Memory words 0..2 = 0x48, 0x69, 0x00; start pulse; char_ready=1 -> chars 'H', 'i' emitted; rd_addr sequence 0x000, 0x004, 0x008; done pulse; count=2; no third char.
REQ-034 Word 0 = 0x00 -> no char_valid; done pulse 3 cycles after start is sampled; count=0.
REQ-035 Word 0 = 0xFFFFFF41; char_ready held low 5 cycles -> char_o='A' stable with char_valid=1 throughout; one acceptance; upper bytes ignored.
REQ-036 All 700 words = 0x2E; char_ready=1 -> exactly 700 '.' chars; last rd_addr = 0xAEC; count=700; done pulse; index does not wrap.
REQ-037 rst asserted in EMIT of char 2 -> char_valid=0 at once; count=0; no done pulse; a new start rescans from rd_addr 0.
REQ-038 start pulsed while busy -> ignored; the scan completes normally with one done pulse.
